// File: rtl/reg_bank_pkg.sv
// Shared definitions for the parametrised register bank: write-op encodings and op width.
package reg_bank_pkg;

    localparam int OP_W = 2;

    typedef enum logic [OP_W-1:0] {
        OP_LOAD    = 2'b00,
        OP_ADD_SAT = 2'b01,
        OP_SUB_SAT = 2'b10,
        OP_CLEAR   = 2'b11
    } wr_op_e;

endpackage

// File: rtl/reg_cell.sv
// One bank entry: WIDTH-bit register with synchronous reset, load enable and next-value input.
module reg_cell #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // NOTE: non-blocking assignment so every flop samples values from before the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/param_reg_bank.sv
// DEPTH x WIDTH register bank with load / saturating add / saturating subtract / clear ops,
// registered read-first port and status flags. Define REG_BANK_SHADOW_EN for snap/restore.
module param_reg_bank
    import reg_bank_pkg::*;
#(
    parameter  int WIDTH  = 8,
    parameter  int DEPTH  = 4,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [OP_W-1:0]   wr_op,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
`ifdef REG_BANK_SHADOW_EN
    input  logic              snap,
    input  logic              restore,
`endif
    output logic [WIDTH-1:0]  rd_data,
    output logic [DEPTH-1:0]  valid,
    output logic              sat,
    output logic              addr_err
);

    logic [WIDTH-1:0] live_q [DEPTH];
    logic [DEPTH-1:0] hit_vec;
    logic             wr_in_range;
    logic             rd_in_range;
    logic             wr_fire;
    logic             do_restore;
    logic [WIDTH-1:0] cur_val;
    logic [WIDTH-1:0] rd_val;
    logic [WIDTH-1:0] new_val;
    logic [WIDTH:0]   sum;
    logic             new_sat;
    logic             new_valid;

    // Address checks only exist when DEPTH leaves unused codes in the address space.
    if ((2 ** ADDR_W) == DEPTH) begin : g_pow2
        assign wr_in_range = 1'b1;
        assign rd_in_range = 1'b1;
    end else begin : g_npow2
        localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);
        assign wr_in_range = {1'b0, wr_addr} < DEPTH_W;
        assign rd_in_range = {1'b0, rd_addr} < DEPTH_W;
    end

`ifdef REG_BANK_SHADOW_EN
    logic [WIDTH-1:0] shadow_q [DEPTH];
    logic [DEPTH-1:0] shadow_valid;
    logic             do_snap;

    assign do_restore = restore;
    assign do_snap    = snap && !restore;
`else
    assign do_restore = 1'b0;
`endif

    // A restore owns the live entries for this cycle, so any write is dropped.
    assign wr_fire = wr_en && wr_in_range && !do_restore;

    always_comb begin
        cur_val = '0;
        rd_val  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_addr == ADDR_W'(i)) cur_val = live_q[i];
            if (rd_in_range && (rd_addr == ADDR_W'(i))) rd_val = live_q[i];
        end
    end

    // NOTE: every output gets a default before the case so no path infers a latch.
    always_comb begin
        sum       = {1'b0, cur_val} + {1'b0, wr_data};
        new_val   = cur_val;
        new_sat   = 1'b0;
        new_valid = 1'b1;
        case (wr_op_e'(wr_op))
            OP_LOAD: new_val = wr_data;
            OP_ADD_SAT: begin
                new_val = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
                new_sat = sum[WIDTH];
            end
            OP_SUB_SAT: begin
                new_sat = wr_data > cur_val;
                new_val = new_sat ? '0 : cur_val - wr_data;
            end
            OP_CLEAR: begin
                new_val   = '0;
                new_valid = 1'b0;
            end
            default: new_val = cur_val;
        endcase
    end

    // NOTE: entries are discrete flops rather than a RAM, so the whole bank resets in one edge.
    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        logic             load;
        logic [WIDTH-1:0] d;

        assign hit_vec[i] = wr_fire && (wr_addr == ADDR_W'(i));

`ifdef REG_BANK_SHADOW_EN
        assign load = hit_vec[i] || do_restore;
        assign d    = do_restore ? shadow_q[i] : new_val;

        reg_cell #(.WIDTH(WIDTH)) u_shadow (
            .clk   (clk),
            .reset (reset),
            .load  (do_snap),
            .d     (live_q[i]),
            .q     (shadow_q[i])
        );
`else
        assign load = hit_vec[i];
        assign d    = new_val;
`endif

        reg_cell #(.WIDTH(WIDTH)) u_live (
            .clk   (clk),
            .reset (reset),
            .load  (load),
            .d     (d),
            .q     (live_q[i])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data  <= '0;
            valid    <= '0;
            sat      <= 1'b0;
            addr_err <= 1'b0;
        end else begin
            rd_data  <= rd_val;
            addr_err <= wr_en && !wr_in_range;
            if (wr_fire && new_sat) sat <= 1'b1;
`ifdef REG_BANK_SHADOW_EN
            if (do_restore) valid <= shadow_valid;
            else            valid <= (valid & ~hit_vec) | (hit_vec & {DEPTH{new_valid}});
`else
            valid <= (valid & ~hit_vec) | (hit_vec & {DEPTH{new_valid}});
`endif
        end
    end

`ifdef REG_BANK_SHADOW_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_valid <= '0;
        end else if (do_snap) begin
            shadow_valid <= valid;
        end
    end
`endif

endmodule

// File: tb/tb_param_reg_bank.sv
// Self-checking bench: DEPTH=4 and DEPTH=3 banks driven in lockstep against an array-based model.
module tb_param_reg_bank;

    logic       clk;
    logic       reset;
    logic       wr_en;
    logic [1:0] wr_op;
    logic [1:0] wr_addr;
    logic [7:0] wr_data;
    logic [1:0] rd_addr;
`ifdef REG_BANK_SHADOW_EN
    logic       snap;
    logic       restore;
`endif

    logic [7:0] rd_data4, rd_data3;
    logic [3:0] valid4;
    logic [2:0] valid3;
    logic       sat4, sat3, err4, err3;

    int total = 0;
    int bad   = 0;

    // Reference state: index 0 models DEPTH=4, index 1 models DEPTH=3.
    int mem     [2][4];
    bit vld     [2][4];
    int sh      [2][4];
    bit shv     [2][4];
    bit msat    [2];
    bit exp_err [2];
    int exp_rd  [2];
    int depth   [2] = '{4, 3};

    param_reg_bank #(.WIDTH(8), .DEPTH(4)) u_dut4 (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_op    (wr_op),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_addr  (rd_addr),
`ifdef REG_BANK_SHADOW_EN
        .snap     (snap),
        .restore  (restore),
`endif
        .rd_data  (rd_data4),
        .valid    (valid4),
        .sat      (sat4),
        .addr_err (err4)
    );

    param_reg_bank #(.WIDTH(8), .DEPTH(3)) u_dut3 (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_op    (wr_op),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_addr  (rd_addr),
`ifdef REG_BANK_SHADOW_EN
        .snap     (snap),
        .restore  (restore),
`endif
        .rd_data  (rd_data3),
        .valid    (valid3),
        .sat      (sat3),
        .addr_err (err3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Applies one clock edge of the bank's rules to both model instances.
    task automatic model_edge();
        bit sn;
        bit rs;
        int a;
        int s;
        int old  [4];
        bit oldv [4];
        sn = 1'b0;
        rs = 1'b0;
`ifdef REG_BANK_SHADOW_EN
        sn = snap;
        rs = restore;
`endif
        a = int'(wr_addr);
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                for (int i = 0; i < 4; i++) begin
                    mem[k][i] = 0; vld[k][i] = 0; sh[k][i] = 0; shv[k][i] = 0;
                end
                msat[k] = 0; exp_err[k] = 0; exp_rd[k] = 0;
            end else begin
                exp_rd[k]  = (int'(rd_addr) < depth[k]) ? mem[k][rd_addr] : 0;
                exp_err[k] = wr_en && (a >= depth[k]);
                for (int i = 0; i < 4; i++) begin
                    old[i] = mem[k][i]; oldv[i] = vld[k][i];
                end
                if (rs) begin
                    for (int i = 0; i < depth[k]; i++) begin
                        mem[k][i] = sh[k][i]; vld[k][i] = shv[k][i];
                    end
                end else if (wr_en && a < depth[k]) begin
                    case (wr_op)
                        2'd0: begin mem[k][a] = int'(wr_data); vld[k][a] = 1; end
                        2'd1: begin
                            s = mem[k][a] + int'(wr_data);
                            if (s > 255) begin mem[k][a] = 255; msat[k] = 1; end
                            else mem[k][a] = s;
                            vld[k][a] = 1;
                        end
                        2'd2: begin
                            if (int'(wr_data) > mem[k][a]) begin mem[k][a] = 0; msat[k] = 1; end
                            else mem[k][a] = mem[k][a] - int'(wr_data);
                            vld[k][a] = 1;
                        end
                        default: begin mem[k][a] = 0; vld[k][a] = 0; end
                    endcase
                end
                if (sn && !rs) begin
                    for (int i = 0; i < depth[k]; i++) begin
                        sh[k][i] = old[i]; shv[k][i] = oldv[i];
                    end
                end
            end
        end
    endtask

    function automatic int mask(input int k);
        int m = 0;
        for (int i = 0; i < depth[k]; i++) if (vld[k][i]) m |= (1 << i);
        return m;
    endfunction

    task automatic check_all();
        check("d4_rd_data",  {24'b0, rd_data4}, exp_rd[0]);
        check("d4_valid",    {28'b0, valid4},   mask(0));
        check("d4_sat",      {31'b0, sat4},     {31'b0, msat[0]});
        check("d4_addr_err", {31'b0, err4},     {31'b0, exp_err[0]});
        check("d3_rd_data",  {24'b0, rd_data3}, exp_rd[1]);
        check("d3_valid",    {29'b0, valid3},   mask(1));
        check("d3_sat",      {31'b0, sat3},     {31'b0, msat[1]});
        check("d3_addr_err", {31'b0, err3},     {31'b0, exp_err[1]});
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic drive(input bit en, input logic [1:0] op, input logic [1:0] a,
                         input logic [7:0] d, input logic [1:0] ra);
        wr_en = en; wr_op = op; wr_addr = a; wr_data = d; rd_addr = ra;
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 2'd0, 2'd0, 8'h00, 2'd0);
`ifdef REG_BANK_SHADOW_EN
        snap = 1'b0; restore = 1'b0;
`endif
        step();
        step();
        check("reset_rd_data", {24'b0, rd_data4}, 32'h0);
        check("reset_valid",   {28'b0, valid4},   32'h0);
        reset = 1'b0;

        // Load entry 1 and read it back.
        drive(1, 2'd0, 2'd1, 8'h35, 2'd1); step();
        drive(0, 2'd0, 2'd1, 8'h00, 2'd1); step();
        check("t1_rd_data", {24'b0, rd_data4}, 32'h35);
        check("t1_valid",   {28'b0, valid4},   32'h2);

        // Saturating add clamps to all-ones and sat sticks.
        drive(1, 2'd0, 2'd0, 8'hF0, 2'd0); step();
        drive(1, 2'd1, 2'd0, 8'h20, 2'd0); step();
        drive(0, 2'd0, 2'd0, 8'h00, 2'd0); step();
        check("t2_rd_data", {24'b0, rd_data4}, 32'hFF);
        check("t2_sat",     {31'b0, sat4},     32'h1);
        step();
        check("t2_sat_sticky", {31'b0, sat4}, 32'h1);

        reset = 1'b1; step(); reset = 1'b0;

        // Saturating subtract clamps to zero; zero operand leaves value alone.
        drive(1, 2'd0, 2'd2, 8'h10, 2'd2); step();
        drive(1, 2'd2, 2'd2, 8'h18, 2'd2); step();
        check("t3_sat", {31'b0, sat4}, 32'h1);
        drive(1, 2'd2, 2'd2, 8'h00, 2'd2); step();
        drive(0, 2'd0, 2'd2, 8'h00, 2'd2); step();
        check("t3_rd_data", {24'b0, rd_data4}, 32'h0);
        check("t3_valid",   {28'b0, valid4},   32'h4);

        // Read-first on a same-cycle write; out-of-range address on the 3-deep bank.
        drive(1, 2'd0, 2'd3, 8'h55, 2'd3); step();
        check("t4_rd_old",  {24'b0, rd_data4}, 32'h0);
        check("t5_err_hi",  {31'b0, err3},     32'h1);
        drive(0, 2'd0, 2'd3, 8'h00, 2'd3); step();
        check("t4_rd_new",  {24'b0, rd_data4}, 32'h55);
        check("t5_err_lo",  {31'b0, err3},     32'h0);
        check("t5_valid3",  {29'b0, valid3},   32'h4);

        // Reset beats a concurrent write.
        reset = 1'b1;
        drive(1, 2'd0, 2'd0, 8'hAA, 2'd3); step();
        reset = 1'b0;
        check("t5_reset_valid", {28'b0, valid4}, 32'h0);
        check("t5_reset_rd",    {24'b0, rd_data4}, 32'h0);

`ifdef REG_BANK_SHADOW_EN
        // Snapshot, overwrite, restore with a dropped same-cycle write.
        drive(1, 2'd0, 2'd0, 8'h11, 2'd0); step();
        drive(0, 2'd0, 2'd0, 8'h00, 2'd0); snap = 1'b1; step(); snap = 1'b0;
        drive(1, 2'd0, 2'd0, 8'h22, 2'd0); step();
        drive(1, 2'd0, 2'd0, 8'h33, 2'd0); restore = 1'b1; step(); restore = 1'b0;
        drive(0, 2'd0, 2'd0, 8'h00, 2'd0); step();
        check("t6_rd_data", {24'b0, rd_data4}, 32'h11);
`endif

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            reset   = ($urandom_range(0, 39) == 0);
            wr_en   = ($urandom_range(0, 3) != 0);
            wr_op   = 2'($urandom_range(0, 3));
            wr_addr = 2'($urandom_range(0, 3));
            rd_addr = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0:       wr_data = 8'h00;
                1:       wr_data = 8'hFF;
                default: wr_data = 8'($urandom);
            endcase
`ifdef REG_BANK_SHADOW_EN
            snap    = ($urandom_range(0, 7) == 0);
            restore = ($urandom_range(0, 9) == 0);
`endif
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
